// File: rtl/checker_pkg.sv
// Shared types and constants for the result checker.
// EXP holds the expected Result sequence for the single-cycle core program.
package checker_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int NUM_TESTS_DEF = 21;
  localparam int EXP_DEPTH     = 21;

  typedef enum logic [1:0] {
    SKIP  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } chk_state_t;

  localparam logic [31:0] EXP [0:EXP_DEPTH-1] = '{
    32'h00000000, 32'h00000001, 32'h00000002, 32'h00000004,
    32'h00000005, 32'h00000007, 32'h00000008, 32'h0000000B,
    32'h00000003, 32'hFFFFFFFE, 32'h00000000, 32'h00000005,
    32'h00000001, 32'hFFFFFFF4, 32'h000004D2, 32'hFFFFF8D7,
    32'h00000001, 32'hFFFFFB2C, 32'h00000030, 32'h00000030,
    32'h00000030
  };

endpackage

// File: rtl/expected_rom.sv
// Combinational index-to-value lookup over the expected-result table.
// Indices outside the table read as zero.
module expected_rom
  import checker_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] value
);

  always_comb begin
    value = '0;
    for (int i = 0; i < EXP_DEPTH; i++) begin
      if (32'(idx) == i) begin
        value = DATA_W'(EXP[i]);
      end
    end
  end

endmodule

// File: rtl/result_checker.sv
// Compares each retired processor Result against the expected table,
// counting passes/failures and capturing the first mismatch.
module result_checker
  import checker_pkg::*;
#(
  parameter int NUM_TESTS   = NUM_TESTS_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SKIP_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_W-1:0]              result,
  input  logic                           result_valid,
  output logic [$clog2(NUM_TESTS+1)-1:0] test_idx,
  output logic [$clog2(NUM_TESTS+1)-1:0] pass_count,
  output logic [$clog2(NUM_TESTS+1)-1:0] fail_count,
  output logic                           done,
  output logic                           all_pass,
  output logic [$clog2(NUM_TESTS+1)-1:0] first_fail_idx,
  output logic [DATA_W-1:0]              first_fail_value
);

  localparam int CW  = $clog2(NUM_TESTS + 1);
  localparam int SKW = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES + 1) : 1;
  localparam chk_state_t RESET_STATE = (SKIP_CYCLES == 0) ? CHECK : SKIP;

  chk_state_t        state_q, state_d;
  logic [SKW-1:0]    skip_cnt_q, skip_cnt_d;
  logic [CW-1:0]     test_idx_q, test_idx_d;
  logic [CW-1:0]     pass_count_q, pass_count_d;
  logic [CW-1:0]     fail_count_q, fail_count_d;
  logic [CW-1:0]     first_fail_idx_q, first_fail_idx_d;
  logic [DATA_W-1:0] first_fail_value_q, first_fail_value_d;
  logic              fail_seen_q, fail_seen_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] exp_value;

  expected_rom #(
    .DATA_W (DATA_W),
    .IDX_W  (CW)
  ) u_rom (
    .idx   (test_idx_q),
    .value (exp_value)
  );

  // Nothing moves unless result_valid is high; DONE is terminal until reset.
  always_comb begin
    state_d            = state_q;
    skip_cnt_d         = skip_cnt_q;
    test_idx_d         = test_idx_q;
    pass_count_d       = pass_count_q;
    fail_count_d       = fail_count_q;
    first_fail_idx_d   = first_fail_idx_q;
    first_fail_value_d = first_fail_value_q;
    fail_seen_d        = fail_seen_q;
    done_d             = done_q;
    case (state_q)
      SKIP: begin
        if (result_valid) begin
          skip_cnt_d = skip_cnt_q - SKW'(1);
          if (skip_cnt_q <= SKW'(1)) begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        if (result_valid) begin
          if (result == exp_value) begin
            pass_count_d = pass_count_q + CW'(1);
          end else begin
            fail_count_d = fail_count_q + CW'(1);
            if (!fail_seen_q) begin
              first_fail_idx_d   = test_idx_q;
              first_fail_value_d = result;
              fail_seen_d        = 1'b1;
            end
          end
          test_idx_d = test_idx_q + CW'(1);
          if (test_idx_q == CW'(NUM_TESTS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
      end
      default: state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= RESET_STATE;
      skip_cnt_q         <= SKW'(SKIP_CYCLES);
      test_idx_q         <= '0;
      pass_count_q       <= '0;
      fail_count_q       <= '0;
      first_fail_idx_q   <= '0;
      first_fail_value_q <= '0;
      fail_seen_q        <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      skip_cnt_q         <= skip_cnt_d;
      test_idx_q         <= test_idx_d;
      pass_count_q       <= pass_count_d;
      fail_count_q       <= fail_count_d;
      first_fail_idx_q   <= first_fail_idx_d;
      first_fail_value_q <= first_fail_value_d;
      fail_seen_q        <= fail_seen_d;
      done_q             <= done_d;
    end
  end

  assign test_idx         = test_idx_q;
  assign pass_count       = pass_count_q;
  assign fail_count       = fail_count_q;
  assign done             = done_q;
  assign all_pass         = done_q && (fail_count_q == '0);
  assign first_fail_idx   = first_fail_idx_q;
  assign first_fail_value = first_fail_value_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed self-checking bench for result_checker: one SKIP_CYCLES=1
// instance and one SKIP_CYCLES=0 instance sharing clock and reset.
module tb_result_checker;

  logic        clk;
  logic        reset;
  logic [31:0] result;
  logic        result_valid;
  logic [31:0] result0;
  logic        result_valid0;

  logic [4:0]  test_idx, pass_count, fail_count, first_fail_idx;
  logic        done, all_pass;
  logic [31:0] first_fail_value;

  logic [4:0]  test_idx0, pass_count0, fail_count0, first_fail_idx0;
  logic        done0, all_pass0;
  logic [31:0] first_fail_value0;

  int n_cmp;
  int n_fail;

  logic [31:0] exp_tab [0:20];

  result_checker #(.NUM_TESTS(21), .DATA_W(32), .SKIP_CYCLES(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .result           (result),
    .result_valid     (result_valid),
    .test_idx         (test_idx),
    .pass_count       (pass_count),
    .fail_count       (fail_count),
    .done             (done),
    .all_pass         (all_pass),
    .first_fail_idx   (first_fail_idx),
    .first_fail_value (first_fail_value)
  );

  result_checker #(.NUM_TESTS(21), .DATA_W(32), .SKIP_CYCLES(0)) dut0 (
    .clk              (clk),
    .reset            (reset),
    .result           (result0),
    .result_valid     (result_valid0),
    .test_idx         (test_idx0),
    .pass_count       (pass_count0),
    .fail_count       (fail_count0),
    .done             (done0),
    .all_pass         (all_pass0),
    .first_fail_idx   (first_fail_idx0),
    .first_fail_value (first_fail_value0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Inputs change 1 ns after the rising edge; outputs are read at the same point.
  task automatic drive(input logic [31:0] v, input logic vld);
    result       = v;
    result_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    result        = 32'h0;
    result_valid  = 1'b0;
    result0       = 32'h0;
    result_valid0 = 1'b0;
    reset         = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #5;
    n_cmp++;
    if (test_idx !== 5'd0 || pass_count !== 5'd0 || fail_count !== 5'd0) begin
      $display("FAIL reset_counters: got idx=%0d pass=%0d fail=%0d, want 0/0/0", test_idx, pass_count, fail_count);
      n_fail++;
    end
    n_cmp++;
    if (done !== 1'b0 || all_pass !== 1'b0 || first_fail_idx !== 5'd0 || first_fail_value !== 32'h0) begin
      $display("FAIL reset_status: got done=%b all_pass=%b ffi=%0d ffv=%h, want 0/0/0/0", done, all_pass, first_fail_idx, first_fail_value);
      n_fail++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_all_pass();
    do_reset();
    drive(32'h0000_00AA, 1'b1);
    n_cmp++;
    if (test_idx !== 5'd0 || pass_count !== 5'd0 || fail_count !== 5'd0) begin
      $display("FAIL skip_no_compare: got idx=%0d pass=%0d fail=%0d, want 0/0/0", test_idx, pass_count, fail_count);
      n_fail++;
    end
    drive(exp_tab[0], 1'b1);
    n_cmp++;
    if (test_idx !== 5'd1 || pass_count !== 5'd1) begin
      $display("FAIL first_compare: got idx=%0d pass=%0d, want 1/1", test_idx, pass_count);
      n_fail++;
    end
    for (int i = 1; i < 20; i++) drive(exp_tab[i], 1'b1);
    n_cmp++;
    if (done !== 1'b0 || test_idx !== 5'd20) begin
      $display("FAIL before_last: got done=%b idx=%0d, want 0/20", done, test_idx);
      n_fail++;
    end
    drive(exp_tab[20], 1'b1);
    n_cmp++;
    if (done !== 1'b1 || pass_count !== 5'd21 || fail_count !== 5'd0 || all_pass !== 1'b1) begin
      $display("FAIL all_pass_end: got done=%b pass=%0d fail=%0d all_pass=%b, want 1/21/0/1", done, pass_count, fail_count, all_pass);
      n_fail++;
    end
  endtask

  task automatic test_after_done();
    for (int i = 0; i < 5; i++) drive(32'h1234_5678, 1'b1);
    n_cmp++;
    if (pass_count !== 5'd21 || fail_count !== 5'd0 || test_idx !== 5'd21 || done !== 1'b1) begin
      $display("FAIL after_done_hold: got pass=%0d fail=%0d idx=%0d done=%b, want 21/0/21/1", pass_count, fail_count, test_idx, done);
      n_fail++;
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    drive(32'h0, 1'b1);
    for (int i = 0; i < 21; i++) begin
      if (i == 9) drive(32'hFFFF_FFFF, 1'b1);
      else if (i == 13) drive(32'h0, 1'b1);
      else drive(exp_tab[i], 1'b1);
      if (i == 9) begin
        n_cmp++;
        if (fail_count !== 5'd1 || first_fail_idx !== 5'd9 || first_fail_value !== 32'hFFFF_FFFF) begin
          $display("FAIL first_mismatch: got fail=%0d ffi=%0d ffv=%h, want 1/9/ffffffff", fail_count, first_fail_idx, first_fail_value);
          n_fail++;
        end
      end
    end
    n_cmp++;
    if (fail_count !== 5'd2 || pass_count !== 5'd19 || done !== 1'b1 || all_pass !== 1'b0) begin
      $display("FAIL mismatch_counts: got fail=%0d pass=%0d done=%b all_pass=%b, want 2/19/1/0", fail_count, pass_count, done, all_pass);
      n_fail++;
    end
    n_cmp++;
    if (first_fail_idx !== 5'd9 || first_fail_value !== 32'hFFFF_FFFF) begin
      $display("FAIL mismatch_capture: got ffi=%0d ffv=%h, want 9/ffffffff", first_fail_idx, first_fail_value);
      n_fail++;
    end
  endtask

  task automatic test_gap();
    do_reset();
    drive(32'h0, 1'b1);
    for (int i = 0; i <= 4; i++) drive(exp_tab[i], 1'b1);
    for (int g = 0; g < 3; g++) begin
      drive(32'hDEAD_BEEF, 1'b0);
      n_cmp++;
      if (test_idx !== 5'd5 || pass_count !== 5'd5 || fail_count !== 5'd0) begin
        $display("FAIL gap_hold[%0d]: got idx=%0d pass=%0d fail=%0d, want 5/5/0", g, test_idx, pass_count, fail_count);
        n_fail++;
      end
    end
    for (int i = 5; i < 21; i++) drive(exp_tab[i], 1'b1);
    n_cmp++;
    if (pass_count !== 5'd21 || fail_count !== 5'd0 || done !== 1'b1) begin
      $display("FAIL gap_end: got pass=%0d fail=%0d done=%b, want 21/0/1", pass_count, fail_count, done);
      n_fail++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(32'h0, 1'b1);
    for (int i = 0; i <= 10; i++) drive(i == 3 ? 32'h5555_5555 : exp_tab[i], 1'b1);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (test_idx !== 5'd0 || pass_count !== 5'd0 || fail_count !== 5'd0 || first_fail_idx !== 5'd0 || first_fail_value !== 32'h0 || done !== 1'b0) begin
      $display("FAIL mid_reset_clear: got idx=%0d pass=%0d fail=%0d ffi=%0d ffv=%h done=%b, want all 0", test_idx, pass_count, fail_count, first_fail_idx, first_fail_value, done);
      n_fail++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(32'h0, 1'b1);
    n_cmp++;
    if (test_idx !== 5'd0) begin
      $display("FAIL mid_reset_reskip: got idx=%0d, want 0", test_idx);
      n_fail++;
    end
    for (int i = 0; i < 21; i++) drive(exp_tab[i], 1'b1);
    n_cmp++;
    if (pass_count !== 5'd21 || fail_count !== 5'd0 || done !== 1'b1 || all_pass !== 1'b1) begin
      $display("FAIL mid_reset_replay: got pass=%0d fail=%0d done=%b all_pass=%b, want 21/0/1/1", pass_count, fail_count, done, all_pass);
      n_fail++;
    end
  endtask

  task automatic test_skip_zero();
    do_reset();
    for (int i = 0; i < 21; i++) begin
      result0       = exp_tab[i];
      result_valid0 = 1'b1;
      @(posedge clk);
      #1;
      if (i == 0) begin
        n_cmp++;
        if (pass_count0 !== 5'd1 || test_idx0 !== 5'd1) begin
          $display("FAIL skip0_first: got pass=%0d idx=%0d, want 1/1", pass_count0, test_idx0);
          n_fail++;
        end
      end
      if (i == 19) begin
        n_cmp++;
        if (done0 !== 1'b0 || pass_count0 !== 5'd20) begin
          $display("FAIL skip0_before_last: got done=%b pass=%0d, want 0/20", done0, pass_count0);
          n_fail++;
        end
      end
    end
    result_valid0 = 1'b0;
    n_cmp++;
    if (done0 !== 1'b1 || pass_count0 !== 5'd21 || all_pass0 !== 1'b1) begin
      $display("FAIL skip0_end: got done=%b pass=%0d all_pass=%b, want 1/21/1", done0, pass_count0, all_pass0);
      n_fail++;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    exp_tab = '{
      32'h00000000, 32'h00000001, 32'h00000002, 32'h00000004,
      32'h00000005, 32'h00000007, 32'h00000008, 32'h0000000B,
      32'h00000003, 32'hFFFFFFFE, 32'h00000000, 32'h00000005,
      32'h00000001, 32'hFFFFFFF4, 32'h000004D2, 32'hFFFFF8D7,
      32'h00000001, 32'hFFFFFB2C, 32'h00000030, 32'h00000030,
      32'h00000030
    };
    result        = 32'h0;
    result_valid  = 1'b0;
    result0       = 32'h0;
    result_valid0 = 1'b0;
    reset         = 1'b0;

    test_reset();
    test_all_pass();
    test_after_done();
    test_mismatch();
    test_gap();
    test_mid_reset();
    test_skip_zero();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
